// File: rtl/dcache_store_port.sv
// Direct-mapped write-back/write-allocate store port: commits one store per request, evicting/refilling over a word-wide memory port.
// Optional hit/miss/evict counters are compiled in with `define DCACHE_STORE_STATS_EN.
module dcache_store_port #(
  parameter int LINES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sb_write_cache,
  input  logic [31:0] sb_address,
  input  logic [31:0] sb_data,
  output logic        dhit,
  output logic        busy,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
`ifdef DCACHE_STORE_STATS_EN
  ,
  output logic [31:0] stat_hits,
  output logic [31:0] stat_misses,
  output logic [31:0] stat_evicts
`endif
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 28 - IDX_W;

  typedef enum logic [2:0] {IDLE, LOOKUP, EVICT, FILL, COMMIT} state_t;

  state_t state_q, state_d;

  logic [31:0]      st_addr_q;
  logic [31:0]      st_data_q;
  logic [1:0]       beat_q;
  logic             dhit_q;
  logic             accept;

  logic [31:0]      arr_data [LINES][4];
  logic [TAG_W-1:0] arr_tag  [LINES];
  logic [LINES-1:0] arr_valid;
  logic [LINES-1:0] arr_dirty;
  logic [31:0]      lbuf [4];

  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic [1:0]       req_off;
  logic             hit;
  logic             beat_last;

  assign req_idx   = st_addr_q[3+IDX_W:4];
  assign req_tag   = st_addr_q[31:4+IDX_W];
  assign req_off   = st_addr_q[3:2];
  assign hit       = arr_valid[req_idx] && (arr_tag[req_idx] == req_tag);
  assign beat_last = mem_ready && (beat_q == 2'd3);

  assign dhit = dhit_q;
  assign busy = (state_q != IDLE);

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    case (state_q)
      IDLE: begin
        // The cycle carrying dhit still sees the old request, so it is ignored.
        if (sb_write_cache && !dhit_q) begin
          accept  = 1'b1;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit)
          state_d = IDLE;
        else if (arr_valid[req_idx] && arr_dirty[req_idx])
          state_d = EVICT;
        else
          state_d = FILL;
      end
      EVICT: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {arr_tag[req_idx], req_idx, beat_q, 2'b00};
        mem_wdata = arr_data[req_idx][beat_q];
        if (beat_last)
          state_d = FILL;
      end
      FILL: begin
        mem_req  = 1'b1;
        mem_addr = {req_tag, req_idx, beat_q, 2'b00};
        if (beat_last)
          state_d = COMMIT;
      end
      COMMIT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      beat_q    <= 2'd0;
      dhit_q    <= 1'b0;
      st_addr_q <= 32'd0;
      st_data_q <= 32'd0;
      arr_valid <= '0;
      arr_dirty <= '0;
    end else begin
      state_q <= state_d;
      dhit_q  <= 1'b0;
      if (accept) begin
        st_addr_q <= sb_address;
        st_data_q <= sb_data;
      end
      if (state_q == LOOKUP && hit) begin
        arr_dirty[req_idx] <= 1'b1;
        dhit_q             <= 1'b1;
      end
      if (mem_req && mem_ready)
        beat_q <= beat_q + 2'd1;
      if (state_q == EVICT && beat_last)
        arr_dirty[req_idx] <= 1'b0;
      if (state_q == COMMIT) begin
        arr_valid[req_idx] <= 1'b1;
        arr_dirty[req_idx] <= 1'b1;
        dhit_q             <= 1'b1;
      end
    end
  end

  // Data and tag storage carry no reset; validity alone decides what they mean.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == FILL && mem_ready)
        lbuf[beat_q] <= mem_rdata;
      if (state_q == LOOKUP && hit)
        arr_data[req_idx][req_off] <= st_data_q;
      if (state_q == COMMIT) begin
        for (int w = 0; w < 4; w++)
          arr_data[req_idx][w] <= (2'(w) == req_off) ? st_data_q : lbuf[w];
        arr_tag[req_idx] <= req_tag;
      end
    end
  end

`ifdef DCACHE_STORE_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_hits   <= 32'd0;
      stat_misses <= 32'd0;
      stat_evicts <= 32'd0;
    end else begin
      if (state_q == LOOKUP && hit && stat_hits != 32'hFFFF_FFFF)
        stat_hits <= stat_hits + 32'd1;
      if (state_q == LOOKUP && !hit && stat_misses != 32'hFFFF_FFFF)
        stat_misses <= stat_misses + 32'd1;
      if (state_q == EVICT && beat_last && stat_evicts != 32'hFFFF_FFFF)
        stat_evicts <= stat_evicts + 32'd1;
    end
  end
`endif

endmodule
